// File: rtl/cfg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cfg_pkg                                                    |
// | Description : Shared definitions for the serial config loader: default   |
// |               register geometry, frame length, FSM state encoding and    |
// |               the RW header bit values.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cfg_pkg;

    localparam int unsigned c_addr_w    = 3;
    localparam int unsigned c_data_w    = 16;
    // RW bit + address + data, sent MSB first
    localparam int unsigned c_frame_len = 1 + c_addr_w + c_data_w;

    localparam logic c_rw_write = 1'b1;
    localparam logic c_rw_read  = 1'b0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR      = 3'd1,
        WR_DATA  = 3'd2,
        WR_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        RD_SHIFT = 3'd5,
        DRAIN    = 3'd6
    } state_t;

endpackage : cfg_pkg
`default_nettype wire

// File: rtl/cfg_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cfg_sync_edge                                              |
// | Description : N-flop synchroniser for an asynchronous level, with        |
// |               optional rise/fall pulses taken from the synchronised      |
// |               output and one extra history flop.                         |
// | Ports       : clk, reset (async active-low), i_async (raw input),        |
// |               o_sync (synchronised level), o_rise/o_fall (1-clk pulses). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cfg_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter bit          RESET_VAL = 1'b0,
    parameter bit          EDGE_EN   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            // History flop: the edge is seen exactly when the synchronised
            // level first differs from its previous value.
            logic r_last;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_last <= RESET_VAL;
                end else begin
                    r_last <= r_sync[STAGES-1];
                end
            end

            assign o_rise = r_sync[STAGES-1] & ~r_last;
            assign o_fall = ~r_sync[STAGES-1] & r_last;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
            assign o_fall = 1'b0;
        end
    endgenerate

endmodule : cfg_sync_edge
`default_nettype wire

// File: rtl/cfg_serial_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cfg_serial_loader                                          |
// | Description : SPI-style frame deserialiser feeding config_reg's parallel |
// |               port. Frame = RW, address, data (MSB first). Writes issue  |
// |               a single cfg_write strobe; reads fetch cfg_rdata and shift |
// |               it back on miso. All serial inputs are oversampled on clk. |
// | Ports       : clk, reset (async active-low)                              |
// |               cs_n, sclk, mosi (async serial in), miso (serial out)      |
// |               cfg_write, cfg_addr, cfg_wdata, cfg_rdata (config_reg)     |
// |               busy (frame in progress), frame_err (abort pulse)          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cfg_serial_loader
    import cfg_pkg::*;
#(
    parameter int unsigned ADDR_W      = c_addr_w,
    parameter int unsigned DATA_W      = c_data_w,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              cfg_write,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_wdata,
    input  logic [DATA_W-1:0] cfg_rdata,
    output logic              busy,
    output logic              frame_err
);

    localparam int unsigned c_frame_bits = 1 + ADDR_W + DATA_W;
    localparam int unsigned c_cnt_w      = $clog2(c_frame_bits + 1);
    localparam int unsigned c_wait_w     = $clog2(RD_LAT + 2);

    // Bit count seen when the last header bit arrives, the count once the
    // header is complete, and the count seen when the final frame bit arrives.
    localparam logic [c_cnt_w-1:0]  c_hdr_last = c_cnt_w'(ADDR_W);
    localparam logic [c_cnt_w-1:0]  c_hdr_done = c_cnt_w'(ADDR_W + 1);
    localparam logic [c_cnt_w-1:0]  c_last_bit = c_cnt_w'(c_frame_bits - 1);
    localparam logic [c_wait_w-1:0] c_rd_lat   = c_wait_w'(RD_LAT);

    logic w_cs_n, w_cs_fall, w_cs_rise;
    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic [3:0] w_unused_sync;

    cfg_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_EN(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .i_async(cs_n),
        .o_sync(w_cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    cfg_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sclk_sync (
        .clk(clk), .reset(reset), .i_async(sclk),
        .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    cfg_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .i_async(mosi),
        .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_sync = {w_cs_rise, w_sclk_sync, w_mosi_rise, w_mosi_fall};

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_bit_cnt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [ADDR_W-1:0]   r_hdr;   // RW + address bits received so far
    logic [DATA_W-2:0]   r_rx;    // data bits received so far
    logic [DATA_W-2:0]   r_tx;    // read bits still to present after miso
    logic                r_miso;
    logic                r_cfg_write;
    logic [ADDR_W-1:0]   r_cfg_addr;
    logic [DATA_W-1:0]   r_cfg_wdata;
    logic                r_frame_err;

    logic [ADDR_W:0]   w_hdr_next;
    logic [DATA_W-1:0] w_rx_next;

    assign w_hdr_next = {r_hdr, w_mosi};
    assign w_rx_next  = {r_rx, w_mosi};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_hdr       <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_miso      <= 1'b0;
            r_cfg_write <= 1'b0;
            r_cfg_addr  <= '0;
            r_cfg_wdata <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_cfg_write <= 1'b0;
            r_frame_err <= 1'b0;
            if ((r_state != IDLE) && (r_state != DRAIN) && w_cs_n) begin
                // Host released cs_n mid-frame: drop everything, no write.
                r_state     <= IDLE;
                r_frame_err <= 1'b1;
                r_miso      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= HDR;
                            r_bit_cnt <= '0;
                            r_hdr     <= '0;
                        end
                    end
                    HDR: begin
                        if (w_sclk_rise) begin
                            r_hdr     <= w_hdr_next[ADDR_W-1:0];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_hdr_last) begin
                                r_cfg_addr <= w_hdr_next[ADDR_W-1:0];
                                if (w_hdr_next[ADDR_W] == c_rw_write) begin
                                    r_state <= WR_DATA;
                                    r_rx    <= '0;
                                end else begin
                                    r_state    <= RD_WAIT;
                                    r_wait_cnt <= '0;
                                end
                            end
                        end
                    end
                    WR_DATA: begin
                        if (w_sclk_rise) begin
                            r_rx      <= w_rx_next[DATA_W-2:0];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_last_bit) begin
                                r_cfg_wdata <= w_rx_next;
                                r_state     <= WR_ISSUE;
                            end
                        end
                    end
                    WR_ISSUE: begin
                        r_cfg_write <= 1'b1;
                        r_state     <= DRAIN;
                    end
                    RD_WAIT: begin
                        // cfg_addr has been stable since entry; after RD_LAT
                        // further clocks cfg_rdata reflects it.
                        if (r_wait_cnt == c_rd_lat) begin
                            r_miso  <= cfg_rdata[DATA_W-1];
                            r_tx    <= cfg_rdata[DATA_W-2:0];
                            r_state <= RD_SHIFT;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                    RD_SHIFT: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_last_bit) begin
                                r_state <= DRAIN;
                                r_miso  <= 1'b0;
                            end
                        end else if (w_sclk_fall && (r_bit_cnt != c_hdr_done)) begin
                            // The falling edge trailing the last header bit may
                            // land here; the MSB must stay up until the host
                            // has sampled it, so only shift once a data bit
                            // has been clocked.
                            r_miso <= r_tx[DATA_W-2];
                            r_tx   <= {r_tx[DATA_W-3:0], 1'b0};
                        end
                    end
                    DRAIN: begin
                        r_miso <= 1'b0;
                        if (w_cs_n) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign miso      = r_miso;
    assign cfg_write = r_cfg_write;
    assign cfg_addr  = r_cfg_addr;
    assign cfg_wdata = r_cfg_wdata;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule : cfg_serial_loader
`default_nettype wire

// File: tb/tb_cfg_serial_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cfg_serial_loader                                       |
// | Description : Self-checking bench for cfg_serial_loader. A bench-side    |
// |               SPI master drives frames; an expected-write queue and an   |
// |               expected register image predict cfg_write traffic and     |
// |               miso read data. A simple config_reg stand-in answers       |
// |               cfg_rdata with one clock of latency.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cfg_serial_loader;

    localparam int c_frame = 20;
    localparam int c_half  = 8;    // sclk half period in clk cycles

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        cs_n  = 1'b1;
    logic        sclk  = 1'b0;
    logic        mosi  = 1'b0;
    logic        miso;
    logic        cfg_write;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata = 16'h0;
    logic        busy;
    logic        frame_err;

    int n_vec    = 0;
    int n_err    = 0;
    int n_writes = 0;
    int n_ferr   = 0;
    int exp_ferr = 0;

    logic [15:0] mem     [8] = '{default: 16'h0};
    logic [15:0] exp_mem [8] = '{default: 16'h0};
    logic [18:0] exp_q [$];

    always #5 clk = ~clk;

    cfg_serial_loader #(
        .ADDR_W(3), .DATA_W(16), .SYNC_STAGES(2), .RD_LAT(1)
    ) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
        .miso(miso), .cfg_write(cfg_write), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .busy(busy),
        .frame_err(frame_err)
    );

    // config_reg stand-in: registered read, one clock latency
    always @(posedge clk) begin
        if (cfg_write) mem[cfg_addr] <= cfg_wdata;
        cfg_rdata <= mem[cfg_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        logic [18:0] e;
        if (reset) begin
            if (frame_err) n_ferr++;
            if (cfg_write) begin
                n_writes++;
                check("write_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(cfg_addr), 32'(e[18:16]));
                    check("write_data", 32'(cfg_wdata), 32'(e[15:0]));
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send nbits sclk pulses of frame {rw, addr, data}; extra bits carry 0.
    // end_cs=0 leaves cs_n low (frame left hanging for the caller).
    task automatic send_frame(input logic rw, input logic [2:0] addr, input logic [15:0] data,
                              input int nbits, input bit end_cs, output logic [15:0] rd);
        logic [19:0] frame;
        frame = {rw, addr, data};
        rd    = 16'h0;
        if (rw && nbits >= c_frame) begin
            exp_q.push_back({addr, data});
            exp_mem[addr] = data;
        end
        if (nbits < c_frame && end_cs) exp_ferr++;
        cs_n = 1'b0;
        wait_clks(4);
        check("busy_in_frame", 32'(busy), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < c_frame) ? frame[c_frame-1-i] : 1'b0;
            wait_clks(c_half);
            if (!rw && i >= 4 && i < c_frame) begin
                check("miso_bit", 32'(miso), 32'(exp_mem[addr][c_frame-1-i]));
                rd = {rd[14:0], miso};
            end
            sclk = 1'b1;
            wait_clks(c_half);
            sclk = 1'b0;
        end
        if (end_cs) begin
            wait_clks(c_half);
            cs_n = 1'b1;
            mosi = 1'b0;
            wait_clks(8);
            check("busy_after_frame", 32'(busy), 32'd0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_miso"},      32'(miso),      32'd0);
        check({tag, "_cfg_write"}, 32'(cfg_write), 32'd0);
        check({tag, "_cfg_addr"},  32'(cfg_addr),  32'd0);
        check({tag, "_cfg_wdata"}, 32'(cfg_wdata), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        logic [15:0] rd;

        // Reset state
        wait_clks(3);
        check_outputs_zero("reset");
        reset = 1'b1;
        wait_clks(4);

        // Write 0x0FFF to addr 4, then read it back
        send_frame(1'b1, 3'd4, 16'h0FFF, 20, 1'b1, rd);
        check("wr4_addr_hold",  32'(cfg_addr),  32'h4);
        check("wr4_wdata_hold", 32'(cfg_wdata), 32'h0FFF);
        send_frame(1'b0, 3'd4, 16'h0, 20, 1'b1, rd);
        check("rd4_word", 32'(rd), 32'h0FFF);

        // Write 0x2525 to addr 5, read it back serially
        send_frame(1'b1, 3'd5, 16'h2525, 20, 1'b1, rd);
        send_frame(1'b0, 3'd5, 16'h0, 20, 1'b1, rd);
        check("rd5_word", 32'(rd), 32'h2525);
        check("writes_so_far", 32'(n_writes), 32'd2);

        // Abort after 10 bits of a write frame
        send_frame(1'b1, 3'd1, 16'h5A5A, 10, 1'b1, rd);
        check("abort_err_count", 32'(n_ferr), 32'd1);
        check("abort_no_write", 32'(n_writes), 32'd2);

        // Reset in the middle of the data phase
        send_frame(1'b1, 3'd2, 16'hA5A5, 8, 1'b0, rd);
        #3 reset = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clks(4);
        reset = 1'b1;
        wait_clks(4);
        send_frame(1'b1, 3'd2, 16'hA5A5, 20, 1'b1, rd);
        send_frame(1'b0, 3'd2, 16'h0, 20, 1'b1, rd);
        check("rd2_word", 32'(rd), 32'hA5A5);

        // Over-long write frame, then back-to-back write
        send_frame(1'b1, 3'd3, 16'hBEEF, 24, 1'b1, rd);
        send_frame(1'b1, 3'd6, 16'h1234, 20, 1'b1, rd);
        send_frame(1'b0, 3'd6, 16'h0, 20, 1'b1, rd);
        check("rd6_word", 32'(rd), 32'h1234);
        send_frame(1'b0, 3'd3, 16'h0, 20, 1'b1, rd);
        check("rd3_word", 32'(rd), 32'hBEEF);

        // Final bookkeeping
        wait_clks(4);
        check("total_writes", 32'(n_writes), 32'd5);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        check("frame_err_count", 32'(n_ferr), 32'(exp_ferr));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cfg_serial_loader
`default_nettype wire
